aes_decipher_iter: RTL
======================

// Module: aes_decipher_iter
// PURPOSE
//  Iterative, parametrised AES inverse cipher (FIPS-197) for AES-128/192/256.
//  Expands a loaded key once, word-serially, into an internal round-key file.
//  Then decrypts any number of 128-bit blocks at one round per clock.
//  Uses valid/ready handshakes on key, input and output.
//  Sits beside the encrypt core as the area-lean decrypt path of the AES subsystem.
// PARAMETERS
//  KEY_BITS  256  key length: 128, 192 or 256 (any other value is an elaboration error)
//  NK        KEY_BITS/32  (derived, localparam) key words
//  NR        NK+6         (derived, localparam) rounds: 10/12/14
// PORTS
//  clk        in   1    clock, rising edge
//  rst        in   1    synchronous, active-high reset
//  key_valid  in   1    key presented
//  key_ready  out  1    key accepted when key_valid&key_ready
//  key        in   256  cipher key; w[0]=key[255:224]; KEY_BITS<256 uses MSBs, LSBs ignored
//  in_valid   in   1    ciphertext presented
//  in_ready   out  1    ciphertext accepted when in_valid&in_ready
//  datain     in   128  ciphertext; byte0=datain[127:120] (FIPS byte order)
//  out_valid  out  1    plaintext valid
//  out_ready  in   1    consumer accepts when out_valid&out_ready
//  dataout    out  128  plaintext, same byte order
//  key_loaded out  1    a complete expanded key is resident
// BEHAVIOUR
//  Reset: state=IDLE; key_ready=1, in_ready=0, out_valid=0, key_loaded=0, dataout=0.
//  Reset mid-operation aborts expansion or decryption; key_loaded clears; no output is produced.
//  FSM states: IDLE, KEXP, ROUND, HOLD.
//  IDLE: key_ready=1; in_ready=key_loaded.
//   If key_valid and in_valid are both high, the key wins: go to KEXP and leave in_valid pending.
//   If only in_valid is high and key_loaded=1: go to ROUND.
//  KEXP: key_loaded=0 from the accepting edge.
//   Accept: rk words w[0..NK-1]=key, counter i=NK.
//   Each cycle: compute w[i] from w[i-1] and w[i-NK] using SubWord/RotWord/Rcon, plus the extra SubWord when NK=8 and i%8==4.
//   Exactly one S-box word lookup per cycle.
//   The last word written is w[4*NR+3]; then key_loaded=1 and go to IDLE.
//   Expansion takes 4*(NR+1)-NK cycles: 40 / 46 / 52.
//   key_ready=0, in_ready=0 throughout.
//  ROUND: the accepting edge loads state=datain^rk[NR], with round counter r=1.
//   Each cycle: state = InvMixColumns(AddRoundKey(InvSubBytes(InvShiftRows(state)), rk[NR-r])).
//   InvMixColumns is omitted when r==NR.
//   After the r==NR edge: dataout=state, out_valid=1, go to HOLD.
//   out_valid first rises NR cycles after the accepting edge.
//  HOLD: dataout and out_valid are stable until out_ready.
//   On the handshake edge: out_valid=0, go to IDLE.
//   Throughput is NR+2 cycles per block with out_ready tied high.
//   key_ready=0 and in_ready=0 during ROUND and HOLD; a key never changes under an in-flight block.
//  Round key rk[j] = {w[4j],w[4j+1],w[4j+2],w[4j+3]}.
//   Stored as a 4*(NR+1) x 32 register file.
//   Written only in KEXP; read one 128-bit key per cycle in ROUND.
//  Reloading a key is allowed any time in IDLE; the old key is discarded at acceptance.
//  All arithmetic is GF(2^8) mod x^8+x^4+x^3+x+1. Rcon is 8 bits; the index never exceeds 10.
// STRUCTURE
//  Package aes_pkg:
//   - sbox and inv_sbox functions (256-entry constant tables)
//   - xtime, gmul (constant multiplies 9/11/13/14)
//   - rcon(i)
//   - state enum {IDLE,KEXP,ROUND,HOLD}
//   - function nr_of(KEY_BITS)
//  Sub-module aes_inv_round (combinational):
//   - inputs state, round key, last flag
//   - output next state
//   - instantiated once
//  Key schedule and FSM stay in the top module.
// TESTING
//  KEY_BITS=256, key=000102..1f, datain=8ea2b7ca516745bfeafc49904b496089
//   -> dataout=00112233445566778899aabbccddeeff.
//   key_loaded rises 52 cycles after key accept; out_valid rises 14 cycles after data accept.
//  KEY_BITS=128, key=000102..0f (in MSBs), datain=69c4e0d86a7b0430d8cdb78070b4c55a
//   -> dataout=00112233445566778899aabbccddeeff, out_valid rises 10 cycles after data accept.
//  KEY_BITS=192, key=000102..17, datain=dda97ca4864cdfe06eaf70a0ec0d7191
//   -> dataout=00112233445566778899aabbccddeeff, expansion takes 46 cycles.
//  Hold out_ready=0 for 20 cycles -> dataout stable, out_valid=1, in_ready=0 and key_ready=0 throughout.
//   Release -> one handshake, then in_ready=1 the next cycle.
//  Assert rst during the 7th round and during KEXP cycle 20 -> next cycle all outputs at reset values.
//   key_loaded=0; an in_valid before a new key is not accepted.
//  key_valid and in_valid both high in IDLE with key_loaded=1 -> key accepted first.
//   The block then decrypts with the NEW key; back-to-back blocks with out_ready=1 are spaced NR+2 cycles.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES definitions: S-box tables, GF(2^8) helpers, round constants,
// the control-state encoding and the key-length-to-rounds mapping.
package aes_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      KEXP  = 2'd1,
      ROUND = 2'd2,
      HOLD  = 2'd3
   } state_e;

   // Byte 0 sits in the MSBs so the table reads left to right like FIPS-197.
   localparam logic [2047:0] SBOX_TBL = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

   localparam logic [2047:0] INV_SBOX_TBL = {
      128'h52096ad53036a538bf40a39e81f3d7fb,
      128'h7ce339829b2fff87348e4344c4dee9cb,
      128'h547b9432a6c2233dee4c950b42fac34e,
      128'h082ea16628d924b2765ba2496d8bd125,
      128'h72f8f66486689816d4a45ccc5d65b692,
      128'h6c704850fdedb9da5e154657a78d9d84,
      128'h90d8ab008cbcd30af7e45805b8b34506,
      128'hd02c1e8fca3f0f02c1afbd0301138a6b,
      128'h3a9111414f67dcea97f2cfcef0b4e673,
      128'h96ac7422e7ad3585e2f937e81c75df6e,
      128'h47f11a711d29c5896fb7620eaa18be1b,
      128'hfc563e4bc6d279209adbc0fe78cd5af4,
      128'h1fdda8338807c731b11210592780ec5f,
      128'h60517fa919b54a0d2de57a9f93c99cef,
      128'ha0e03b4dae2af5b0c8ebbb3c83539961,
      128'h172b047eba77d626e169146355210c7d
   };

   // 8*(255-x) == {~x,3'b0}, which selects byte x from the MSB end.
   function automatic logic [7:0] sbox(input logic [7:0] x);
      return SBOX_TBL[{~x, 3'b000} +: 8];
   endfunction

   function automatic logic [7:0] inv_sbox(input logic [7:0] x);
      return INV_SBOX_TBL[{~x, 3'b000} +: 8];
   endfunction

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   // Multiply by a 4-bit constant (9/11/13/14 in practice).
   function automatic logic [7:0] gmul(input logic [7:0] b,
                                      input logic [3:0] c);
      logic [7:0] x2;
      logic [7:0] x4;
      logic [7:0] x8;
      x2 = xtime(b);
      x4 = xtime(x2);
      x8 = xtime(x4);
      return (c[0] ? b  : 8'h00) ^ (c[1] ? x2 : 8'h00) ^
             (c[2] ? x4 : 8'h00) ^ (c[3] ? x8 : 8'h00);
   endfunction

   function automatic logic [7:0] rcon(input logic [3:0] i);
      logic [7:0] r;
      case (i)
         4'd1:    r = 8'h01;
         4'd2:    r = 8'h02;
         4'd3:    r = 8'h04;
         4'd4:    r = 8'h08;
         4'd5:    r = 8'h10;
         4'd6:    r = 8'h20;
         4'd7:    r = 8'h40;
         4'd8:    r = 8'h80;
         4'd9:    r = 8'h1b;
         4'd10:   r = 8'h36;
         default: r = 8'h00;
      endcase
      return r;
   endfunction

   function automatic int nr_of(input int key_bits);
      return key_bits / 32 + 6;
   endfunction

endpackage

// File: rtl/aes_inv_round.sv
// One AES inverse round: InvShiftRows, InvSubBytes, AddRoundKey and,
// except on the final round, InvMixColumns. Purely combinational.
module aes_inv_round
   import aes_pkg::*;
(
   input  logic [127:0] state_i,
   input  logic [127:0] rk_i,
   input  logic         last_i,
   output logic [127:0] state_o
);

   logic [7:0] ark [16];

   // Row r rotates right by r; byte index is row + 4*column.
   always_comb begin
      ark = '{default: 8'h00};
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) begin
            ark[4*c+r] =
               inv_sbox(state_i[8*(15-(4*((c-r+4)%4)+r)) +: 8]) ^
               rk_i[8*(15-(4*c+r)) +: 8];
         end
      end
   end

   // Column mix with the {0e,0b,0d,09} circulant, bypassed on the last round.
   always_comb begin
      state_o = '0;
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) begin
            if (last_i) begin
               state_o[8*(15-(4*c+r)) +: 8] = ark[4*c+r];
            end else begin
               state_o[8*(15-(4*c+r)) +: 8] =
                  gmul(ark[4*c+r],         4'd14) ^
                  gmul(ark[4*c+(r+1)%4],   4'd11) ^
                  gmul(ark[4*c+(r+2)%4],   4'd13) ^
                  gmul(ark[4*c+(r+3)%4],   4'd9);
            end
         end
      end
   end

endmodule

// File: rtl/aes_decipher_iter.sv
// Iterative AES-128/192/256 inverse cipher: word-serial key expansion
// into a local round-key file, then one decryption round per clock.
module aes_decipher_iter
   import aes_pkg::*;
#(
   parameter int KEY_BITS = 256
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         key_valid,
   output logic         key_ready,
   input  logic [255:0] key,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] datain,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] dataout,
   output logic         key_loaded
);

   localparam int NK = KEY_BITS / 32;
   localparam int NR = nr_of(KEY_BITS);
   localparam int NW = 4 * (NR + 1);
   localparam int IW = $clog2(NW);

   if (KEY_BITS != 128 && KEY_BITS != 192 && KEY_BITS != 256) begin : g_bad_key
      $error("aes_decipher_iter: KEY_BITS must be 128, 192 or 256");
   end

   state_e         state_q, state_d;
   logic [31:0]    w_q [NW];
   logic [31:0]    w_d [NW];
   logic [IW-1:0]  i_q, i_d;
   logic [2:0]     kpos_q, kpos_d;
   logic [3:0]     rc_q, rc_d;
   logic [3:0]     r_q, r_d;
   logic [127:0]   blk_q, blk_d;
   logic [127:0]   dout_q, dout_d;
   logic           kl_q, kl_d;

   logic [3:0]     rk_idx;
   logic [IW-1:0]  rk_base;
   logic [127:0]   rk;
   logic [127:0]   rnd_out;
   logic           last_rnd;
   logic [31:0]    prev_w, far_w, sub_in, sub_w, new_w;

   assign key_ready  = (state_q == IDLE);
   assign in_ready   = (state_q == IDLE) && kl_q && !key_valid;
   assign out_valid  = (state_q == HOLD);
   assign dataout    = dout_q;
   assign key_loaded = kl_q;
   assign last_rnd   = (r_q == 4'(NR));

   // Round-key select: rk[NR] for the initial whitening, rk[NR-r] per round.
   always_comb begin
      rk_idx  = (state_q == ROUND) ? 4'(NR) - r_q : 4'(NR);
      rk_base = IW'({rk_idx, 2'b00});
      rk = {w_q[rk_base],
            w_q[rk_base + IW'(1)],
            w_q[rk_base + IW'(2)],
            w_q[rk_base + IW'(3)]};
   end

   // Next schedule word; a single shared SubWord serves both cases.
   always_comb begin
      prev_w = w_q[i_q - IW'(1)];
      far_w  = w_q[i_q - IW'(NK)];
      sub_in = (kpos_q == 3'd0) ? {prev_w[23:0], prev_w[31:24]} : prev_w;
      sub_w  = {sbox(sub_in[31:24]), sbox(sub_in[23:16]),
                sbox(sub_in[15:8]),  sbox(sub_in[7:0])};
      if (kpos_q == 3'd0) begin
         new_w = far_w ^ sub_w ^ {rcon(rc_q), 24'h000000};
      end else if (NK == 8 && kpos_q == 3'd4) begin
         new_w = far_w ^ sub_w;
      end else begin
         new_w = far_w ^ prev_w;
      end
   end

   aes_inv_round u_round (
      .state_i (blk_q),
      .rk_i    (rk),
      .last_i  (last_rnd),
      .state_o (rnd_out)
   );

   // Control FSM: key wins over data in IDLE, key file only written in KEXP.
   always_comb begin
      state_d = state_q;
      w_d     = w_q;
      i_d     = i_q;
      kpos_d  = kpos_q;
      rc_d    = rc_q;
      r_d     = r_q;
      blk_d   = blk_q;
      dout_d  = dout_q;
      kl_d    = kl_q;
      unique case (state_q)
         IDLE: begin
            if (key_valid) begin
               for (int k = 0; k < NK; k++) begin
                  w_d[k] = key[255-32*k -: 32];
               end
               i_d     = IW'(NK);
               kpos_d  = 3'd0;
               rc_d    = 4'd1;
               kl_d    = 1'b0;
               state_d = KEXP;
            end else if (in_valid && kl_q) begin
               blk_d   = datain ^ rk;
               r_d     = 4'd1;
               state_d = ROUND;
            end
         end
         KEXP: begin
            w_d[i_q] = new_w;
            i_d      = i_q + IW'(1);
            if (kpos_q == 3'(NK - 1)) begin
               kpos_d = 3'd0;
               rc_d   = rc_q + 4'd1;
            end else begin
               kpos_d = kpos_q + 3'd1;
            end
            if (i_q == IW'(NW - 1)) begin
               kl_d    = 1'b1;
               state_d = IDLE;
            end
         end
         ROUND: begin
            blk_d = rnd_out;
            r_d   = r_q + 4'd1;
            if (last_rnd) begin
               dout_d  = rnd_out;
               state_d = HOLD;
            end
         end
         HOLD: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Control and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         i_q     <= '0;
         kpos_q  <= '0;
         rc_q    <= '0;
         r_q     <= '0;
         blk_q   <= '0;
         dout_q  <= '0;
         kl_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         i_q     <= i_d;
         kpos_q  <= kpos_d;
         rc_q    <= rc_d;
         r_q     <= r_d;
         blk_q   <= blk_d;
         dout_q  <= dout_d;
         kl_q    <= kl_d;
      end
   end

   // Round-key file; validity is tracked by key_loaded, so no reset needed.
   always_ff @(posedge clk) begin
      w_q <= w_d;
   end

endmodule
